// File: rtl/keypad_emulator_if.sv
// Keypad emulator request/scan bundle: the controller side (master) drives the
// key request and column scan; the emulator side (slave) returns status and rows.
interface keypad_emulator_if;
  logic [4:0] key_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] col;
  logic [3:0] row;
  logic       pressed;
  logic [7:0] press_count;

  modport master (
    output key_in, start, col,
    input  busy, done, row, pressed, press_count
  );

  modport slave (
    input  key_in, start, col,
    output busy, done, row, pressed, press_count
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad stand-in: answers column scans on the row lines as if the
// latched key were pressed, with programmable bounce, hold and release gap.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 1000,
  parameter int BOUNCE_CYCLES = 0,
  parameter int BOUNCE_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_emulator_if.slave  kp
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_LEN = (BOUNCE_CYCLES > MAX_HG) ? BOUNCE_CYCLES : MAX_HG;
  localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LD = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PER_LD    = PW'(BOUNCE_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_per, w_per_nxt;
  logic          r_pressed, w_pressed_nxt;
  logic          r_done, w_done_nxt;
  logic          r_valid, w_valid_nxt;
  logic [3:0]    r_key, w_key_nxt;
  logic [7:0]    r_count, w_count_nxt;
  logic          w_cnt_zero;
  logic [1:0]    w_key_col;
  logic [1:0]    w_key_row;
  logic [3:0]    w_row;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_per     <= '0;
      r_pressed <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_key     <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_per     <= w_per_nxt;
      r_pressed <= w_pressed_nxt;
      r_done    <= w_done_nxt;
      r_valid   <= w_valid_nxt;
      r_key     <= w_key_nxt;
      r_count   <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (kp.start) w_state_nxt = (BOUNCE_CYCLES > 0) ? S_BOUNCE : S_HOLD;
      S_BOUNCE: if (w_cnt_zero) w_state_nxt = S_HOLD;
      S_HOLD:   if (w_cnt_zero) w_state_nxt = S_GAP;
      S_GAP:    if (w_cnt_zero) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The phase counter and the contact image are computed one cycle ahead so
  // that pressed/done are registered and line up with the state they belong to.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_per_nxt     = r_per;
    w_pressed_nxt = r_pressed;
    w_done_nxt    = 1'b0;
    w_valid_nxt   = r_valid;
    w_key_nxt     = r_key;
    w_count_nxt   = r_count;
    case (r_state)
      S_IDLE: begin
        if (kp.start) begin
          w_valid_nxt   = ~kp.key_in[4];
          w_key_nxt     = kp.key_in[3:0];
          w_pressed_nxt = ~kp.key_in[4];
          w_per_nxt     = PER_LD;
          w_cnt_nxt     = (BOUNCE_CYCLES > 0) ? BOUNCE_LD : HOLD_LD;
          if (!kp.key_in[4]) w_count_nxt = r_count + 8'd1;
        end
      end
      S_BOUNCE: begin
        if (w_cnt_zero) begin
          w_cnt_nxt     = HOLD_LD;
          w_pressed_nxt = r_valid;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_per == '0) begin
            w_per_nxt     = PER_LD;
            w_pressed_nxt = r_valid & ~r_pressed;
          end else begin
            w_per_nxt = r_per - PW'(1);
          end
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_cnt_nxt     = GAP_LD;
          w_pressed_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (w_cnt_zero) w_done_nxt = 1'b1;
        else            w_cnt_nxt  = r_cnt - CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_key)
      4'h1: begin w_key_col = 2'd0; w_key_row = 2'd0; end
      4'h4: begin w_key_col = 2'd0; w_key_row = 2'd1; end
      4'h7: begin w_key_col = 2'd0; w_key_row = 2'd2; end
      4'h0: begin w_key_col = 2'd0; w_key_row = 2'd3; end
      4'h2: begin w_key_col = 2'd1; w_key_row = 2'd0; end
      4'h5: begin w_key_col = 2'd1; w_key_row = 2'd1; end
      4'h8: begin w_key_col = 2'd1; w_key_row = 2'd2; end
      4'hF: begin w_key_col = 2'd1; w_key_row = 2'd3; end
      4'h3: begin w_key_col = 2'd2; w_key_row = 2'd0; end
      4'h6: begin w_key_col = 2'd2; w_key_row = 2'd1; end
      4'h9: begin w_key_col = 2'd2; w_key_row = 2'd2; end
      4'hE: begin w_key_col = 2'd2; w_key_row = 2'd3; end
      4'hA: begin w_key_col = 2'd3; w_key_row = 2'd0; end
      4'hB: begin w_key_col = 2'd3; w_key_row = 2'd1; end
      4'hC: begin w_key_col = 2'd3; w_key_row = 2'd2; end
      default: begin w_key_col = 2'd3; w_key_row = 2'd3; end
    endcase
    w_row = '1;
    if (r_pressed && !kp.col[w_key_col]) w_row[w_key_row] = 1'b0;
  end

  assign kp.busy        = (r_state != S_IDLE);
  assign kp.done        = r_done;
  assign kp.pressed     = r_pressed;
  assign kp.press_count = r_count;
  assign kp.row         = w_row;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: randomized key requests compared
// against a phase-timing and key-matrix reference model.
module tb_keypad_emulator;

  localparam int H0 = 8, G0 = 4, B0 = 0, P0 = 4;
  localparam int H1 = 3, G1 = 2, B1 = 6, P1 = 2;
  localparam int T0 = B0 + H0 + G0;
  localparam int T1 = B1 + H1 + G1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt0 = '0;
  logic [7:0] exp_cnt1 = '0;

  // Physical layout: mat[column][row] = key legend
  int mat [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

  keypad_emulator_if if0 ();
  keypad_emulator_if if1 ();

  keypad_emulator #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .BOUNCE_CYCLES(B0), .BOUNCE_PERIOD(P0))
    dut0 (.clk(clk), .rst(rst), .kp(if0));
  keypad_emulator #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .BOUNCE_CYCLES(B1), .BOUNCE_PERIOD(P1))
    dut1 (.clk(clk), .rst(rst), .kp(if1));

  always #5 clk = ~clk;

  // Expected contact state k cycles after the accepting edge.
  function automatic bit exp_pressed(input logic [4:0] key, input int k, input int b,
                                     input int h, input int p);
    if (key >= 16) return 1'b0;
    if (k < b) return ((k / p) % 2) == 0;
    if (k < b + h) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row(input logic [4:0] key, input bit pr, input logic [3:0] c);
    logic [3:0] r;
    r = 4'b1111;
    if (pr)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (c[i] == 1'b0 && mat[i][j] == int'(key)) r[j] = 1'b0;
    return r;
  endfunction

  task automatic run_seq0(input logic [4:0] key);
    bit ep;
    logic [3:0] c;
    logic [3:0] er;
    if0.key_in = key;
    if0.start  = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    if (key < 16) exp_cnt0 = exp_cnt0 + 8'd1;
    for (int k = 0; k <= T0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ep = exp_pressed(key, k, B0, H0, P0);
      checks++;
      if (if0.pressed !== ep) begin
        errors++; $display("FAIL seq0_pressed key=%0d k=%0d got %b exp %b", key, k, if0.pressed, ep);
      end
      checks++;
      if (if0.busy !== (k < T0)) begin
        errors++; $display("FAIL seq0_busy key=%0d k=%0d got %b exp %b", key, k, if0.busy, k < T0);
      end
      checks++;
      if (if0.done !== (k == T0)) begin
        errors++; $display("FAIL seq0_done key=%0d k=%0d got %b exp %b", key, k, if0.done, k == T0);
      end
      for (int i = 0; i < 5; i++) begin
        c = (i < 4) ? ~(4'b0001 << i) : 4'($urandom);
        if0.col = c;
        #1;
        er = exp_row(key, ep, c);
        checks++;
        if (if0.row !== er) begin
          errors++; $display("FAIL seq0_row key=%0d k=%0d col=%b got %b exp %b", key, k, c, if0.row, er);
        end
      end
    end
    checks++;
    if (if0.press_count !== exp_cnt0) begin
      errors++; $display("FAIL seq0_count key=%0d got %0d exp %0d", key, if0.press_count, exp_cnt0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if0.start = 1'b1; if0.key_in = 5'd3; if0.col = 4'b0000;
    if1.start = 1'b1; if1.key_in = 5'd5; if1.col = 4'b0000;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
      checks++;
      if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if0.done); end
      checks++;
      if (if0.pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b exp 0", if0.pressed); end
      checks++;
      if (if0.press_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if0.press_count); end
      checks++;
      if (if0.row !== 4'b1111) begin errors++; $display("FAIL reset_row got %b exp 1111", if0.row); end
      checks++;
      if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", if1.busy); end
    end
    rst = 1'b0;
    if0.start = 1'b0; if1.start = 1'b0;
    if0.col = 4'b1111; if1.col = 4'b1111;
    exp_cnt0 = '0; exp_cnt1 = '0;
  endtask

  task automatic test_basic;
    run_seq0(5'd6);
  endtask

  task automatic test_key_sweep;
    for (int k = 0; k < 16; k++) run_seq0(5'(k));
  endtask

  task automatic test_random;
    int idle;
    logic [3:0] c;
    for (int n = 0; n < 20; n++) begin
      idle = $urandom_range(0, 3);
      for (int i = 0; i < idle; i++) begin
        @(posedge clk); #1;
        c = 4'($urandom);
        if0.col = c;
        #1;
        checks++;
        if (if0.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", if0.busy); end
        checks++;
        if (if0.row !== 4'b1111) begin errors++; $display("FAIL idle_row col=%b got %b exp 1111", c, if0.row); end
      end
      run_seq0(5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_bounce;
    logic [4:0] key;
    bit ep;
    logic [3:0] c;
    logic [3:0] er;
    for (int n = 0; n < 4; n++) begin
      key = (n == 0) ? 5'd6 : 5'($urandom_range(0, 31));
      if1.key_in = key;
      if1.start  = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      if (key < 16) exp_cnt1 = exp_cnt1 + 8'd1;
      for (int k = 0; k <= T1; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        ep = exp_pressed(key, k, B1, H1, P1);
        checks++;
        if (if1.pressed !== ep) begin
          errors++; $display("FAIL bounce_pressed key=%0d k=%0d got %b exp %b", key, k, if1.pressed, ep);
        end
        checks++;
        if (if1.done !== (k == T1)) begin
          errors++; $display("FAIL bounce_done key=%0d k=%0d got %b exp %b", key, k, if1.done, k == T1);
        end
        checks++;
        if (if1.busy !== (k < T1)) begin
          errors++; $display("FAIL bounce_busy key=%0d k=%0d got %b exp %b", key, k, if1.busy, k < T1);
        end
        c = 4'($urandom);
        if1.col = c;
        #1;
        er = exp_row(key, ep, c);
        checks++;
        if (if1.row !== er) begin
          errors++; $display("FAIL bounce_row key=%0d k=%0d col=%b got %b exp %b", key, k, c, if1.row, er);
        end
      end
      checks++;
      if (if1.press_count !== exp_cnt1) begin
        errors++; $display("FAIL bounce_count got %0d exp %0d", if1.press_count, exp_cnt1);
      end
    end
  endtask

  task automatic test_ignored_start;
    int ndone = 0;
    logic [3:0] c;
    if0.key_in = 5'h10;
    if0.start  = 1'b1;
    @(posedge clk); #1;
    if0.key_in = 5'd6;
    for (int k = 0; k <= T0 + 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == T0 - 1) if0.start = 1'b0;
      if (if0.done === 1'b1) ndone++;
      c = 4'($urandom);
      if0.col = c;
      #1;
      checks++;
      if (if0.row !== 4'b1111) begin
        errors++; $display("FAIL nokey_row k=%0d col=%b got %b exp 1111", k, c, if0.row);
      end
      checks++;
      if (if0.pressed !== 1'b0) begin
        errors++; $display("FAIL nokey_pressed k=%0d got %b exp 0", k, if0.pressed);
      end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL nokey_done_count got %0d exp 1", ndone); end
    checks++;
    if (if0.press_count !== exp_cnt0) begin
      errors++; $display("FAIL nokey_count got %0d exp %0d", if0.press_count, exp_cnt0);
    end
    checks++;
    if (if0.busy !== 1'b0) begin errors++; $display("FAIL nokey_busy_end got %b exp 0", if0.busy); end
  endtask

  task automatic test_back_to_back;
    localparam int PER = T0 + 1;
    int r;
    logic [7:0] ec;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt0 = '0;
    if0.col = 4'b0111;
    if0.key_in = 5'hA;
    if0.start  = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 256 * PER; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      r  = k % PER;
      ec = 8'((k / PER + 1) % 256);
      checks++;
      if (if0.done !== (r == T0)) begin
        errors++; $display("FAIL b2b_done k=%0d got %b exp %b", k, if0.done, r == T0);
      end
      checks++;
      if (if0.busy !== (r != T0)) begin
        errors++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, if0.busy, r != T0);
      end
      checks++;
      if (if0.pressed !== exp_pressed(5'hA, r, B0, H0, P0)) begin
        errors++; $display("FAIL b2b_pressed k=%0d got %b", k, if0.pressed);
      end
      checks++;
      if (if0.press_count !== ec) begin
        errors++; $display("FAIL b2b_count k=%0d got %0d exp %0d", k, if0.press_count, ec);
      end
      if (k == 255 * PER) if0.start = 1'b0;
    end
    exp_cnt0 = '0;
    if0.col = 4'b1111;
  endtask

  task automatic test_reset_mid_hold;
    logic [3:0] c;
    if0.key_in = 5'd6;
    if0.start  = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt0 = '0;
    checks++;
    if (if0.pressed !== 1'b0) begin errors++; $display("FAIL midrst_pressed got %b exp 0", if0.pressed); end
    checks++;
    if (if0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", if0.busy); end
    checks++;
    if (if0.press_count !== 8'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", if0.press_count); end
    for (int i = 0; i < 4; i++) begin
      c = ~(4'b0001 << i);
      if0.col = c;
      #1;
      checks++;
      if (if0.row !== 4'b1111) begin errors++; $display("FAIL midrst_row col=%b got %b exp 1111", c, if0.row); end
    end
    for (int k = 0; k < T0 + 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (if0.done !== 1'b0) begin errors++; $display("FAIL midrst_done k=%0d got %b exp 0", k, if0.done); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    if0.key_in = '0; if0.start = 1'b0; if0.col = 4'b1111;
    if1.key_in = '0; if1.start = 1'b0; if1.col = 4'b1111;
    #1;
    test_reset;
    test_basic;
    test_key_sweep;
    test_random;
    test_bounce;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid_hold;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
